// File: rtl/wb_grant_decoder_pkg.sv
// Shared definitions for the Wishbone grant decoder: FSM encodings and timeout defaults.
package wb_grant_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam int unsigned WbGrantTimeoutDefault = 255;

    // Counter width: enough bits for cycles, clamped to 8..32.
    function automatic int unsigned timer_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 8) w = 8;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/wb_grant_timer.sv
// Saturating GRANT-duration counter; expire_o flags the cycle the limit is reached.
// Only instantiated when WB_GRANT_TIMEOUT_EN is defined.
module wb_grant_timer
    import wb_grant_decoder_pkg::*;
#(
    parameter int unsigned TimeoutCycles = WbGrantTimeoutDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned Width = timer_width(TimeoutCycles);
    localparam logic [Width-1:0] LimitM1 = Width'(TimeoutCycles - 1);
    localparam logic [Width-1:0] CntMax = '1;

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The increment in this cycle is the one that reaches the limit.
    assign expire_o = inc_i && !clr_i && (cnt_q >= LimitM1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_grant_decoder.sv
// Registered one-hot master select held for a whole Wishbone cycle, then released.
// Define WB_GRANT_TIMEOUT_EN to add the GRANT timeout abort (to_err_o).
module wb_grant_decoder
    import wb_grant_decoder_pkg::*;
#(
    parameter int unsigned N              = 2,
    parameter int unsigned TIMEOUT_CYCLES = WbGrantTimeoutDefault,
    localparam int unsigned IDX_W         = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic [IDX_W-1:0] req_index_i,
    input  logic [N-1:0]     m_cyc_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_index_o,
    output logic [N-1:0]     grant_onehot_o,
    output logic             busy_o,
    output logic             to_err_o
);

    localparam logic [IDX_W:0] NumMasters = (IDX_W + 1)'(N);
    localparam logic [N-1:0]   OneHotLsb  = {{(N - 1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             busy_q, busy_d;
    logic             to_err_q, to_err_d;

    logic             req_ok;
    logic             timer_clr;
    logic             timer_inc;
    logic             timer_expire;

    assign req_ok = req_valid_i && ({1'b0, req_index_i} < NumMasters) && m_cyc_i[req_index_i];

`ifdef WB_GRANT_TIMEOUT_EN
    wb_grant_timer #(
        .TimeoutCycles(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (timer_clr),
        .inc_i   (timer_inc),
        .expire_o(timer_expire)
    );
`else
    logic unused_timer;
    assign unused_timer = timer_clr ^ timer_inc ^ s_ack_i ^ s_err_i;
    assign timer_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        to_err_d  = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_ok) begin
                    state_d   = StGrant;
                    idx_d     = req_index_i;
                    timer_clr = 1'b1;
                end
            end
            StGrant: begin
                // Requests are ignored here: no preemption once a master owns the bus.
                timer_clr = s_ack_i || s_err_i;
                timer_inc = !timer_clr;
                if (timer_expire) begin
                    state_d  = StRelease;
                    to_err_d = 1'b1;
                end else if (!m_cyc_i[idx_q]) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        valid_d  = (state_d == StGrant);
        onehot_d = valid_d ? (OneHotLsb << idx_d) : '0;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            busy_q   <= busy_d;
            to_err_q <= to_err_d;
        end
    end

    assign grant_valid_o  = valid_q;
    assign grant_index_o  = idx_q;
    assign grant_onehot_o = onehot_q;
    assign busy_o         = busy_q;
    assign to_err_o       = to_err_q;

endmodule

// File: tb/tb_wb_grant_decoder.sv
// Directed bench for wb_grant_decoder: a 4-master instance (timeout 8) and a 3-master instance.
module tb_wb_grant_decoder;

    logic clk;
    logic rst;

    // N=4 instance
    logic       rv4;
    logic [1:0] ri4;
    logic [3:0] cyc4;
    logic       ack4, err4;
    logic       gv4;
    logic [1:0] gi4;
    logic [3:0] oh4;
    logic       busy4, toe4;

    // N=3 instance
    logic       rv3;
    logic [1:0] ri3;
    logic [2:0] cyc3;
    logic       gv3;
    logic [1:0] gi3;
    logic [2:0] oh3;
    logic       busy3, toe3;

    int checks = 0;
    int errors = 0;

    wb_grant_decoder #(
        .N             (4),
        .TIMEOUT_CYCLES(8)
    ) u_dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (rv4),
        .req_index_i   (ri4),
        .m_cyc_i       (cyc4),
        .s_ack_i       (ack4),
        .s_err_i       (err4),
        .grant_valid_o (gv4),
        .grant_index_o (gi4),
        .grant_onehot_o(oh4),
        .busy_o        (busy4),
        .to_err_o      (toe4)
    );

    wb_grant_decoder #(
        .N(3)
    ) u_dut3 (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (rv3),
        .req_index_i   (ri3),
        .m_cyc_i       (cyc3),
        .s_ack_i       (1'b0),
        .s_err_i       (1'b0),
        .grant_valid_o (gv3),
        .grant_index_o (gi3),
        .grant_onehot_o(oh3),
        .busy_o        (busy3),
        .to_err_o      (toe3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output of the N=4 instance.
    task automatic chk4(input string tag, input logic v, input logic [1:0] idx,
                        input logic [3:0] oh, input logic b, input logic te);
        chk({tag, ".valid"}, 32'(gv4), 32'(v));
        chk({tag, ".index"}, 32'(gi4), 32'(idx));
        chk({tag, ".onehot"}, 32'(oh4), 32'(oh));
        chk({tag, ".busy"}, 32'(busy4), 32'(b));
        chk({tag, ".to_err"}, 32'(toe4), 32'(te));
    endtask

    initial begin
        rst  = 1'b1;
        rv4  = 1'b1;
        ri4  = 2'd2;
        cyc4 = 4'b0100;
        ack4 = 1'b0;
        err4 = 1'b0;
        rv3  = 1'b1;
        ri3  = 2'd1;
        cyc3 = 3'b010;

        // 1: reset held 3 cycles with a valid request pending
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("reset4", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
            chk("reset3.valid", 32'(gv3), 32'd0);
            chk("reset3.busy", 32'(busy3), 32'd0);
        end
        rst = 1'b0;
        rv3 = 1'b0;
        cyc3 = 3'b000;

        // 2: basic grant, hold, release, idle
        tick();
        chk4("basic.grant", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        rv4 = 1'b0;
        tick();
        chk4("basic.hold", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        cyc4 = 4'b0000;
        tick();
        chk4("basic.release", 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0);
        tick();
        chk4("basic.idle", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);

        // 3: no preemption by idx 0 while idx 2 owns the bus
        rv4 = 1'b1; ri4 = 2'd2; cyc4 = 4'b0100;
        tick();
        chk4("nopre.grant", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        ri4 = 2'd0; cyc4 = 4'b0101;
        tick();
        chk4("nopre.hold1", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        tick();
        chk4("nopre.hold2", 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0);
        cyc4 = 4'b0001;
        tick();
        chk4("nopre.release", 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0);
        tick();
        chk4("nopre.gap", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);
        tick();
        chk4("nopre.grant0", 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
        rv4 = 1'b0;

        // CYC drop together with the final ack still goes through RELEASE
        cyc4 = 4'b0000; ack4 = 1'b1;
        tick();
        chk4("ackdrop.release", 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0);
        ack4 = 1'b0;
        tick();
        chk4("ackdrop.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // 5: mid-grant reset drops straight to IDLE
        rv4 = 1'b1; ri4 = 2'd3; cyc4 = 4'b1000;
        tick();
        chk4("midrst.grant", 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk4("midrst.reset", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0; rv4 = 1'b0; cyc4 = 4'b0000;
        tick();
        chk4("midrst.norel", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

        // 4: invalid requests on the 3-master instance
        rv3 = 1'b1; ri3 = 2'd3; cyc3 = 3'b111;
        tick();
        chk("inv.idx3.valid", 32'(gv3), 32'd0);
        chk("inv.idx3.busy", 32'(busy3), 32'd0);
        ri3 = 2'd1; cyc3 = 3'b101;
        tick();
        chk("inv.nocyc.valid", 32'(gv3), 32'd0);
        chk("inv.nocyc.onehot", 32'(oh3), 32'd0);
        cyc3 = 3'b010;
        tick();
        chk("inv.ok.onehot", 32'(oh3), 32'b010);
        chk("inv.ok.to_err", 32'(toe3), 32'd0);
        rv3 = 1'b0; cyc3 = 3'b000;

        // 6: timeout with CYC held and no ack
        rv4 = 1'b1; ri4 = 2'd1; cyc4 = 4'b0010;
        tick();
        chk4("to.grant", 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
        rv4 = 1'b0;
`ifdef WB_GRANT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk4("to.count", 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        tick();
        chk4("to.pulse", 1'b0, 2'd1, 4'b0000, 1'b1, 1'b1);
        tick();
        chk4("to.idle", 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);

        // Periodic acks keep the counter from expiring
        rv4 = 1'b1;
        tick();
        chk4("toack.grant", 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
        rv4 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ack4 = (i % 5 == 4);
            tick();
            chk4("toack.hold", 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        ack4 = 1'b0;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk4("noto.hold", 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
        end
`endif
        cyc4 = 4'b0000;
        tick();
        chk4("end.release", 1'b0, 2'd1, 4'b0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
